// File: rtl/ps2_key_decoder_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ps2_key_decoder_if : scancode byte strobe in, per-key key state out          |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
interface ps2_key_decoder_if #(
  parameter int NUM_KEYS = 4
);
  logic [7:0]          key_byte;
  logic                key_valid;
  logic [NUM_KEYS-1:0] clear_toggle;
  logic [NUM_KEYS-1:0] key_held;
  logic [NUM_KEYS-1:0] key_press;
  logic [NUM_KEYS-1:0] key_release;
  logic [NUM_KEYS-1:0] key_toggle;
  logic [8:0]          last_code;
  logic                seq_error;

  modport master (
    output key_byte, key_valid, clear_toggle,
    input  key_held, key_press, key_release, key_toggle, last_code, seq_error
  );

  modport slave (
    input  key_byte, key_valid, clear_toggle,
    output key_held, key_press, key_release, key_toggle, last_code, seq_error
  );
endinterface
`default_nettype wire

// File: rtl/ps2_key_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ps2_key_decoder : PS/2 Set-2 make/break decoder for NUM_KEYS programmable    |
// | keys. Define PS2_KEY_REPEAT_EN to pulse key_press on typematic repeats.      |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
module ps2_key_decoder #(
  parameter int                    NUM_KEYS       = 4,
  parameter logic [NUM_KEYS*9-1:0] KEY_CODES      = {9'h04D, 9'h029, 9'h174, 9'h16B},
  parameter int                    TIMEOUT_CYCLES = 50000
) (
  input  wire logic        clock,
  input  wire logic        resetn,
  ps2_key_decoder_if.slave bus
);

  localparam logic [2:0] c_ST_IDLE    = 3'd0;
  localparam logic [2:0] c_ST_EXT     = 3'd1;
  localparam logic [2:0] c_ST_BRK     = 3'd2;
  localparam logic [2:0] c_ST_EXT_BRK = 3'd3;
  localparam logic [2:0] c_ST_SKIP_E1 = 3'd4;

  localparam int              c_CW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_CW-1:0] c_TMO_LAST = c_CW'(TIMEOUT_CYCLES - 1);

  localparam logic [7:0] c_B_E0 = 8'hE0;
  localparam logic [7:0] c_B_F0 = 8'hF0;
  localparam logic [7:0] c_B_E1 = 8'hE1;

  logic [2:0]          r_state;
  logic [2:0]          w_state_nxt;
  logic [2:0]          r_skip;
  logic [c_CW-1:0]     r_tmo;

  logic                w_tmo_hit;
  logic                w_fake_shift;
  logic                w_ignored;
  logic                w_make;
  logic                w_brk;
  logic                w_proto_err;
  logic [8:0]          w_code;
  logic [NUM_KEYS-1:0] w_match;

  logic [NUM_KEYS-1:0] r_held;
  logic [NUM_KEYS-1:0] r_press;
  logic [NUM_KEYS-1:0] r_release;
  logic [NUM_KEYS-1:0] r_toggle;
  logic [8:0]          r_last_code;
  logic                r_seq_error;

  assign w_fake_shift = (bus.key_byte == 8'h12) || (bus.key_byte == 8'h59);
  assign w_ignored    = (bus.key_byte == 8'h00) || (bus.key_byte == 8'hAA) ||
                        (bus.key_byte == 8'hFA) || (bus.key_byte == 8'hFC) ||
                        (bus.key_byte == 8'hFD) || (bus.key_byte == 8'hFE) ||
                        (bus.key_byte == 8'hFF);

  // An arriving byte always beats a timeout in the same cycle.
  assign w_tmo_hit = !bus.key_valid && (r_state != c_ST_IDLE) && (r_tmo == c_TMO_LAST);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bus.key_valid) begin
      case (r_state)
        c_ST_IDLE: begin
          if (bus.key_byte == c_B_E0)      w_state_nxt = c_ST_EXT;
          else if (bus.key_byte == c_B_F0) w_state_nxt = c_ST_BRK;
          else if (bus.key_byte == c_B_E1) w_state_nxt = c_ST_SKIP_E1;
        end
        c_ST_EXT: begin
          if (bus.key_byte == c_B_F0)      w_state_nxt = c_ST_EXT_BRK;
          else if (bus.key_byte != c_B_E0) w_state_nxt = c_ST_IDLE;
        end
        c_ST_BRK: begin
          if (bus.key_byte == c_B_E0)      w_state_nxt = c_ST_EXT;
          else if (bus.key_byte != c_B_F0) w_state_nxt = c_ST_IDLE;
        end
        c_ST_EXT_BRK: w_state_nxt = c_ST_IDLE;
        c_ST_SKIP_E1: begin
          if (r_skip == 3'd1) w_state_nxt = c_ST_IDLE;
        end
        default: w_state_nxt = c_ST_IDLE;
      endcase
    end else if (w_tmo_hit) begin
      w_state_nxt = c_ST_IDLE;
    end
  end

  always_comb begin
    w_make      = 1'b0;
    w_brk       = 1'b0;
    w_proto_err = 1'b0;
    w_code      = {1'b0, bus.key_byte};
    if (bus.key_valid) begin
      case (r_state)
        c_ST_IDLE: begin
          if ((bus.key_byte != c_B_E0) && (bus.key_byte != c_B_F0) &&
              (bus.key_byte != c_B_E1) && !w_ignored) begin
            w_make = 1'b1;
          end
        end
        c_ST_EXT: begin
          if ((bus.key_byte != c_B_F0) && (bus.key_byte != c_B_E0) && !w_fake_shift) begin
            w_make = 1'b1;
            w_code = {1'b1, bus.key_byte};
          end
        end
        c_ST_BRK: begin
          if (bus.key_byte == c_B_E0)      w_proto_err = 1'b1;
          else if (bus.key_byte != c_B_F0) w_brk = 1'b1;
        end
        c_ST_EXT_BRK: begin
          if (!w_fake_shift) begin
            w_brk  = 1'b1;
            w_code = {1'b1, bus.key_byte};
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_tmo  <= '0;
      r_skip <= 3'd0;
    end else begin
      if (bus.key_valid || (r_state == c_ST_IDLE) || w_tmo_hit) begin
        r_tmo <= '0;
      end else begin
        r_tmo <= r_tmo + c_CW'(1);
      end
      if (bus.key_valid) begin
        if ((r_state == c_ST_IDLE) && (bus.key_byte == c_B_E1)) begin
          r_skip <= 3'd7;
        end else if (r_state == c_ST_SKIP_E1) begin
          r_skip <= r_skip - 3'd1;
        end
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_match
      assign w_match[gi] = (w_code == KEY_CODES[9*gi +: 9]);
    end
  endgenerate

  // Every slot whose code matches is updated, so duplicate codes move together.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_held      <= '0;
      r_press     <= '0;
      r_release   <= '0;
      r_toggle    <= '0;
      r_last_code <= 9'd0;
      r_seq_error <= 1'b0;
    end else begin
      r_press     <= '0;
      r_release   <= '0;
      r_seq_error <= w_proto_err || w_tmo_hit;
      if (w_make || w_brk) begin
        r_last_code <= w_code;
      end
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (w_make && w_match[i]) begin
          if (!r_held[i]) begin
            r_held[i]   <= 1'b1;
            r_press[i]  <= 1'b1;
            r_toggle[i] <= ~r_toggle[i];
          end
`ifdef PS2_KEY_REPEAT_EN
          else begin
            r_press[i] <= 1'b1;
          end
`endif
        end
        if (w_brk && w_match[i] && r_held[i]) begin
          r_held[i]    <= 1'b0;
          r_release[i] <= 1'b1;
        end
        if (bus.clear_toggle[i]) begin
          r_toggle[i] <= 1'b0;
        end
      end
    end
  end

  assign bus.key_held    = r_held;
  assign bus.key_press   = r_press;
  assign bus.key_release = r_release;
  assign bus.key_toggle  = r_toggle;
  assign bus.last_code   = r_last_code;
  assign bus.seq_error   = r_seq_error;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_decoder.sv
`default_nettype none
// Directed self-checking bench for ps2_key_decoder (default key map, short timeout).
module tb_ps2_key_decoder;
  localparam int T = 20;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  int checks = 0;
  int errors = 0;

  ps2_key_decoder_if #(.NUM_KEYS(4)) bus ();

  ps2_key_decoder #(
    .NUM_KEYS(4),
    .KEY_CODES({9'h04D, 9'h029, 9'h174, 9'h16B}),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clock(clock),
    .resetn(resetn),
    .bus(bus)
  );

  always #5 clock = ~clock;

  task automatic send_byte(input logic [7:0] b);
    bus.key_byte  = b;
    bus.key_valid = 1'b1;
    @(posedge clock); #1;
    bus.key_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clock); #1;
    checks++;
    if ({bus.key_held, bus.key_press, bus.key_release, bus.key_toggle, bus.last_code, bus.seq_error} !== 26'd0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0",
        {bus.key_held, bus.key_press, bus.key_release, bus.key_toggle, bus.last_code, bus.seq_error});
    end
    resetn = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_space();
    send_byte(8'h29);
    checks++; if (bus.key_held !== 4'b0100) begin errors++; $display("FAIL space_held: got %b expected 0100", bus.key_held); end
    checks++; if (bus.key_press !== 4'b0100) begin errors++; $display("FAIL space_press: got %b expected 0100", bus.key_press); end
    checks++; if (bus.key_toggle !== 4'b0100) begin errors++; $display("FAIL space_toggle: got %b expected 0100", bus.key_toggle); end
    checks++; if (bus.last_code !== 9'h029) begin errors++; $display("FAIL space_last: got %h expected 029", bus.last_code); end
    @(posedge clock); #1;
    checks++; if (bus.key_press !== 4'b0000) begin errors++; $display("FAIL space_press_width: got %b expected 0000", bus.key_press); end
    send_byte(8'hF0);
    checks++; if (bus.key_release !== 4'b0000 || bus.key_held !== 4'b0100) begin
      errors++; $display("FAIL space_f0_only: got rel %b held %b expected 0000 0100", bus.key_release, bus.key_held); end
    send_byte(8'h29);
    checks++; if (bus.key_release !== 4'b0100) begin errors++; $display("FAIL space_release: got %b expected 0100", bus.key_release); end
    checks++; if (bus.key_held !== 4'b0000) begin errors++; $display("FAIL space_held_clr: got %b expected 0000", bus.key_held); end
    @(posedge clock); #1;
    checks++; if (bus.key_release !== 4'b0000) begin errors++; $display("FAIL space_release_width: got %b expected 0000", bus.key_release); end
  endtask

  task automatic test_ext_left();
    send_byte(8'hE0); send_byte(8'h6B);
    checks++; if (bus.key_held !== 4'b0001 || bus.key_press !== 4'b0001) begin
      errors++; $display("FAIL left_make: got held %b press %b expected 0001 0001", bus.key_held, bus.key_press); end
    checks++; if (bus.last_code !== 9'h16B) begin errors++; $display("FAIL left_last: got %h expected 16B", bus.last_code); end
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h6B);
    checks++; if (bus.key_held !== 4'b0000 || bus.key_release !== 4'b0001) begin
      errors++; $display("FAIL left_break: got held %b rel %b expected 0000 0001", bus.key_held, bus.key_release); end
    send_byte(8'h12);
    checks++; if (bus.key_held !== 4'b0000 || bus.key_press !== 4'b0000 || bus.last_code !== 9'h012) begin
      errors++; $display("FAIL plain_12: got held %b press %b last %h expected 0000 0000 012", bus.key_held, bus.key_press, bus.last_code); end
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h12);
    checks++; if (bus.last_code !== 9'h012 || bus.key_release !== 4'b0000) begin
      errors++; $display("FAIL fake_shift_brk: got last %h rel %b expected 012 0000", bus.last_code, bus.key_release); end
  endtask

  task automatic test_untracked();
    send_byte(8'h74);
    checks++; if (bus.key_held !== 4'b0000 || bus.last_code !== 9'h074) begin
      errors++; $display("FAIL untracked_74: got held %b last %h expected 0000 074", bus.key_held, bus.last_code); end
  endtask

  task automatic test_typematic();
    int n_press = 0;
    int n_rel = 0;
    for (int k = 0; k < 5; k++) begin
      send_byte((k == 3) ? 8'hF0 : 8'h29);
      n_press += int'(bus.key_press[2]);
      n_rel   += int'(bus.key_release[2]);
    end
`ifdef PS2_KEY_REPEAT_EN
    checks++; if (n_press !== 3) begin errors++; $display("FAIL repeat_press_count: got %0d expected 3", n_press); end
`else
    checks++; if (n_press !== 1) begin errors++; $display("FAIL repeat_press_count: got %0d expected 1", n_press); end
`endif
    checks++; if (n_rel !== 1) begin errors++; $display("FAIL repeat_release_count: got %0d expected 1", n_rel); end
    checks++; if (bus.key_toggle[2] !== 1'b0) begin errors++; $display("FAIL repeat_toggle: got %b expected 0", bus.key_toggle[2]); end
  endtask

  task automatic test_timeout();
    send_byte(8'hE0);
    repeat (T - 1) @(posedge clock);
    #1;
    checks++; if (bus.seq_error !== 1'b0) begin errors++; $display("FAIL tmo_early: got %b expected 0", bus.seq_error); end
    @(posedge clock); #1;
    checks++; if (bus.seq_error !== 1'b1) begin errors++; $display("FAIL tmo_pulse: got %b expected 1", bus.seq_error); end
    @(posedge clock); #1;
    checks++; if (bus.seq_error !== 1'b0) begin errors++; $display("FAIL tmo_width: got %b expected 0", bus.seq_error); end
    send_byte(8'h4D);
    checks++; if (bus.key_press !== 4'b1000 || bus.key_toggle[3] !== 1'b1 || bus.last_code !== 9'h04D) begin
      errors++; $display("FAIL tmo_then_p: got press %b tog %b last %h expected 1000 1 04D", bus.key_press, bus.key_toggle[3], bus.last_code); end
    send_byte(8'hF0); send_byte(8'h4D);
  endtask

  task automatic test_pause();
    logic [7:0] seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    int events = 0;
    for (int k = 0; k < 8; k++) begin
      send_byte(seq[k]);
      if (bus.key_press != 0 || bus.key_release != 0 || bus.seq_error) events++;
    end
    checks++; if (events !== 0 || bus.last_code !== 9'h04D) begin
      errors++; $display("FAIL pause_silent: got events %0d last %h expected 0 04D", events, bus.last_code); end
    send_byte(8'h29);
    checks++; if (bus.key_press !== 4'b0100) begin errors++; $display("FAIL pause_then_idle: got %b expected 0100", bus.key_press); end
    send_byte(8'hF0); send_byte(8'h29);
  endtask

  task automatic test_protocol_error();
    send_byte(8'hF0); send_byte(8'hE0);
    checks++; if (bus.seq_error !== 1'b1) begin errors++; $display("FAIL proto_err: got %b expected 1", bus.seq_error); end
    send_byte(8'h6B);
    checks++; if (bus.key_press !== 4'b0001 || bus.last_code !== 9'h16B) begin
      errors++; $display("FAIL proto_ext: got press %b last %h expected 0001 16B", bus.key_press, bus.last_code); end
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h6B);
  endtask

  task automatic test_clear_toggle();
    bus.clear_toggle = 4'hF;
    @(posedge clock); #1;
    bus.clear_toggle = 4'h0;
    checks++; if (bus.key_toggle !== 4'b0000) begin errors++; $display("FAIL clear_all: got %b expected 0000", bus.key_toggle); end
    bus.clear_toggle = 4'b0100;
    send_byte(8'h29);
    bus.clear_toggle = 4'h0;
    checks++; if (bus.key_toggle[2] !== 1'b0 || bus.key_press[2] !== 1'b1) begin
      errors++; $display("FAIL clear_wins: got tog %b press %b expected 0 1", bus.key_toggle[2], bus.key_press[2]); end
    send_byte(8'hF0); send_byte(8'h29);
  endtask

  task automatic test_back_to_back();
    send_byte(8'h29);
    checks++; if (bus.key_press !== 4'b0100) begin errors++; $display("FAIL b2b_first: got %b expected 0100", bus.key_press); end
    send_byte(8'h4D);
    checks++; if (bus.key_press !== 4'b1000 || bus.key_held !== 4'b1100) begin
      errors++; $display("FAIL b2b_second: got press %b held %b expected 1000 1100", bus.key_press, bus.key_held); end
    send_byte(8'hF0); send_byte(8'h4D);
    checks++; if (bus.key_release !== 4'b1000 || bus.key_held !== 4'b0100) begin
      errors++; $display("FAIL b2b_release: got rel %b held %b expected 1000 0100", bus.key_release, bus.key_held); end
  endtask

  task automatic test_async_reset();
    send_byte(8'hE0); send_byte(8'hF0);
    #3 resetn = 1'b0;
    #1;
    checks++;
    if ({bus.key_held, bus.key_press, bus.key_release, bus.key_toggle, bus.last_code, bus.seq_error} !== 26'd0) begin
      errors++; $display("FAIL async_reset: got %h expected 0",
        {bus.key_held, bus.key_press, bus.key_release, bus.key_toggle, bus.last_code, bus.seq_error});
    end
    @(posedge clock); #1;
    resetn = 1'b1;
    send_byte(8'h6B);
    checks++; if (bus.last_code !== 9'h06B || bus.key_held !== 4'b0000 || bus.key_release !== 4'b0000) begin
      errors++; $display("FAIL reset_fsm_idle: got last %h held %b rel %b expected 06B 0000 0000", bus.last_code, bus.key_held, bus.key_release); end
  endtask

  initial begin
    bus.key_byte     = 8'h00;
    bus.key_valid    = 1'b0;
    bus.clear_toggle = 4'h0;
    test_reset();
    test_space();
    test_ext_left();
    test_untracked();
    test_typematic();
    test_timeout();
    test_pause();
    test_protocol_error();
    test_clear_toggle();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
- Parametrised PS/2 Set-2 scancode decoder; successor to the fixed move_left/move_right/fire/pause decode inside the keyboard interface.
- Consumes the byte strobe from the PS/2 interface (ps2_key_data/ps2_key_pressed).
- Tracks make/break state of NUM_KEYS programmable keys and drives held levels, press/release pulses and per-key toggle flags to the VGA game logic.
- Sits between PS2_Interface and vga_controller.

Parameters:
- NUM_KEYS, 4, number of tracked keys (1..16).
- KEY_CODES, {9'h04D,9'h029,9'h174,9'h16B}, packed NUM_KEYS*9 bits; key i = bits [9i+8:9i]; bit 8 = E0-extended, [7:0] = scancode. Defaults: 0=left arrow, 1=right arrow, 2=space, 3=P.
- TIMEOUT_CYCLES, 50000, prefix timeout in clocks (1 ms at 50 MHz).

Ports:
- clock  input  1  system clock.
- resetn  input  1  asynchronous active-low reset.
- key_byte  input  8  received scancode byte.
- key_valid  input  1  one-cycle strobe; key_byte is valid in that cycle.
- clear_toggle  input  NUM_KEYS  synchronous clear of key_toggle bits.
- key_held  output  NUM_KEYS  level; 1 while key is down.
- key_press  output  NUM_KEYS  one-cycle pulse on the first make.
- key_release  output  NUM_KEYS  one-cycle pulse on break.
- key_toggle  output  NUM_KEYS  flips on each key_press pulse.
- last_code  output  9  {ext,code} of the last completed make/break, tracked or not.
- seq_error  output  1  one-cycle pulse on prefix timeout or protocol violation.

Behaviour:
- Reset (async, resetn=0): all outputs 0; FSM = IDLE; timeout counter = 0.
- FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen), SKIP_E1.
- Transitions, evaluated only on key_valid:
  - IDLE:
    - E0 -> EXT
    - F0 -> BRK
    - E1 -> SKIP_E1 with skip count 7
    - 00/AA/FA/FC/FD/FE/FF -> ignored, stay IDLE
    - other byte -> make {0,byte}, stay IDLE
  - EXT:
    - F0 -> EXT_BRK
    - 12 or 59 (fake shift) -> discard, go IDLE
    - E0 -> stay EXT
    - other byte -> make {1,byte}, go IDLE
  - BRK:
    - F0 -> stay BRK
    - E0 -> seq_error pulse, go EXT
    - other byte -> break {0,byte}, go IDLE
  - EXT_BRK:
    - 12 or 59 -> discard, go IDLE
    - other byte -> break {1,byte}, go IDLE
  - SKIP_E1: decrement count on each byte; go IDLE when it reaches 0. No events are generated.
- Make event for key i (code == KEY_CODES slot i):
  - If key_held[i]=0: set key_held[i], pulse key_press[i], flip key_toggle[i].
  - If already held (typematic repeat): no pulse and no toggle.
- Break event for key i:
  - If key_held[i]=1: clear it and pulse key_release[i].
  - If not held: no output.
- If two slots hold the same code, all matching slots update.
- Output timing:
  - Event registered the cycle after the key_valid that completes the sequence (latency 1).
  - key_press, key_release and seq_error are high exactly one cycle.
  - last_code updates in the same cycle as the event pulses.
- Timeout:
  - Counter runs in any state other than IDLE and resets on each key_valid.
  - When it reaches TIMEOUT_CYCLES-1: go IDLE, pulse seq_error.
  - If key_valid arrives in the same cycle, the byte wins and no timeout occurs.
  - Counter width = clog2(TIMEOUT_CYCLES).
- clear_toggle[i] and a press on the same cycle: clear wins, key_toggle[i]=0.
- key_valid while a pulse is being output: the new event is processed normally; back-to-back pulses are allowed.
- Reset mid-sequence: FSM returns to IDLE; held state is lost and no release pulses are generated.

Optional Feature:
- Macro: PS2_KEY_REPEAT_EN.
- When defined: a repeat make of an already-held key also pulses key_press[i]; key_toggle still flips only on the first make.
- When undefined: repeats are suppressed as above.

Test Plan:
- Bytes 29, F0 29 -> key_held[2] high from the cycle after the first byte; key_press[2] pulses once; key_release[2] pulses after 29 following F0; key_toggle[2]=1; last_code=9'h029.
- E0 6B, E0 F0 6B -> key_held[0] set then cleared; last_code=9'h16B; 12 alone (not E0-prefixed) -> no tracked key changes.
- 74 (non-extended) -> key_held[1] stays 0; last_code=9'h074.
- 29 29 29 F0 29 -> one key_press[2] pulse without the macro, three with PS2_KEY_REPEAT_EN; exactly one key_release[2].
- E0, then TIMEOUT_CYCLES idle clocks -> seq_error pulse and FSM back to IDLE; next 4D -> key_press[3] pulse and key_toggle[3] flips.
- E1 14 77 E1 F0 14 F0 77 -> no events and no seq_error; resetn=0 mid E0 F0 -> all outputs 0 asynchronously.
